// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RISC-V pipeline encodings
package riscv_pkg;
  localparam int REG_IDX_W = 5;
  typedef enum logic [1:0] {
    RES_ALU  = 2'b00,
    RES_LOAD = 2'b01,
    RES_PC4  = 2'b10
  } result_src_e;
  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101,
    ALU_SLL = 3'b110,
    ALU_SRL = 3'b111
  } alu_ctrl_e;
endpackage

// File: rtl/forward_mux.sv
// forward_mux: picks an operand from M, W or the register file; M wins, x0 never forwards
module forward_mux
  import riscv_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [REG_IDX_W-1:0] rs,
  input  logic [N-1:0]         rd,
  input  logic [REG_IDX_W-1:0] rd_m,
  input  logic                 reg_write_m,
  input  logic [N-1:0]         alu_result_m,
  input  logic [REG_IDX_W-1:0] rd_w,
  input  logic                 reg_write_w,
  input  logic [N-1:0]         result_w,
  output logic [N-1:0]         fwd
);
  logic hit_m, hit_w;
  assign hit_m = reg_write_m && rd_m != '0 && rd_m == rs;
  assign hit_w = reg_write_w && rd_w != '0 && rd_w == rs;
  assign fwd = hit_m ? alu_result_m : hit_w ? result_w : rd;
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use stall, flush bubbles and operand forwarding
module id_ex_stage
  import riscv_pkg::*;
#(
  parameter int N = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ValidD,
  input  logic [N-1:0]         RD1D,
  input  logic [N-1:0]         RD2D,
  input  logic [N-1:0]         ImmExtD,
  input  logic [N-1:0]         PCD,
  input  logic [REG_IDX_W-1:0] Rs1D,
  input  logic [REG_IDX_W-1:0] Rs2D,
  input  logic [REG_IDX_W-1:0] RdD,
  input  logic [2:0]           ALUControlD,
  input  logic                 ALUSrcD,
  input  logic                 RegWriteD,
  input  logic                 MemWriteD,
  input  logic [1:0]           ResultSrcD,
  input  logic                 FlushE,
  input  logic [REG_IDX_W-1:0] RdM,
  input  logic                 RegWriteM,
  input  logic [N-1:0]         ALUResultM,
  input  logic [REG_IDX_W-1:0] RdW,
  input  logic                 RegWriteW,
  input  logic [N-1:0]         ResultW,
  output logic [N-1:0]         SrcAE,
  output logic [N-1:0]         SrcBE,
  output logic [2:0]           ALUControlE,
  output logic [N-1:0]         WriteDataE,
  output logic [N-1:0]         PCE,
  output logic [N-1:0]         ImmExtE,
  output logic [REG_IDX_W-1:0] RdE,
  output logic                 RegWriteE,
  output logic                 MemWriteE,
  output logic [1:0]           ResultSrcE,
  output logic                 ValidE,
  output logic                 StallF,
  output logic                 StallD
);
  logic [N-1:0]         rd1_e, rd2_e, fwd_a, fwd_b;
  logic [REG_IDX_W-1:0] rs1_e, rs2_e;
  logic                 alu_src_e, lw_stall, bubble;
  assign lw_stall = ValidE && ValidD && ResultSrcE == RES_LOAD && RdE != '0 && (RdE == Rs1D || RdE == Rs2D);
  assign bubble   = FlushE || lw_stall;
  assign StallF   = lw_stall;
  assign StallD   = lw_stall;
  // E register: a bubble clears every field, otherwise the decoded instruction moves down
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ValidE      <= 1'b0;
      RegWriteE   <= 1'b0;
      MemWriteE   <= 1'b0;
      ResultSrcE  <= '0;
      ALUControlE <= '0;
      alu_src_e   <= 1'b0;
      RdE         <= '0;
      rs1_e       <= '0;
      rs2_e       <= '0;
      rd1_e       <= '0;
      rd2_e       <= '0;
      ImmExtE     <= '0;
      PCE         <= '0;
    end else begin
      ValidE      <= bubble ? 1'b0 : ValidD;
      RegWriteE   <= bubble ? 1'b0 : RegWriteD;
      MemWriteE   <= bubble ? 1'b0 : MemWriteD;
      ResultSrcE  <= bubble ? '0 : ResultSrcD;
      ALUControlE <= bubble ? '0 : ALUControlD;
      alu_src_e   <= bubble ? 1'b0 : ALUSrcD;
      RdE         <= bubble ? '0 : RdD;
      rs1_e       <= bubble ? '0 : Rs1D;
      rs2_e       <= bubble ? '0 : Rs2D;
      rd1_e       <= bubble ? '0 : RD1D;
      rd2_e       <= bubble ? '0 : RD2D;
      ImmExtE     <= bubble ? '0 : ImmExtD;
      PCE         <= bubble ? '0 : PCD;
    end
  end
  forward_mux #(.N(N)) u_fwd_a (
    .rs(rs1_e), .rd(rd1_e),
    .rd_m(RdM), .reg_write_m(RegWriteM), .alu_result_m(ALUResultM),
    .rd_w(RdW), .reg_write_w(RegWriteW), .result_w(ResultW),
    .fwd(fwd_a)
  );
  forward_mux #(.N(N)) u_fwd_b (
    .rs(rs2_e), .rd(rd2_e),
    .rd_m(RdM), .reg_write_m(RegWriteM), .alu_result_m(ALUResultM),
    .rd_w(RdW), .reg_write_w(RegWriteW), .result_w(ResultW),
    .fwd(fwd_b)
  );
  assign SrcAE      = fwd_a;
  assign SrcBE      = alu_src_e ? ImmExtE : fwd_b;
  assign WriteDataE = fwd_b;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed checks of id_ex_stage register, stall, flush, forwarding and reset
module tb_id_ex_stage;
  localparam int N = 32;
  logic         clk = 1'b0;
  logic         reset;
  logic         ValidD, ALUSrcD, RegWriteD, MemWriteD, FlushE, RegWriteM, RegWriteW;
  logic [N-1:0] RD1D, RD2D, ImmExtD, PCD, ALUResultM, ResultW;
  logic [4:0]   Rs1D, Rs2D, RdD, RdM, RdW;
  logic [2:0]   ALUControlD;
  logic [1:0]   ResultSrcD;
  logic [N-1:0] SrcAE, SrcBE, WriteDataE, PCE, ImmExtE;
  logic [2:0]   ALUControlE;
  logic [4:0]   RdE;
  logic         RegWriteE, MemWriteE, ValidE, StallF, StallD;
  logic [1:0]   ResultSrcE;
  int checks = 0;
  int errors = 0;
  id_ex_stage #(.N(N)) dut (
    .clk(clk), .reset(reset),
    .ValidD(ValidD), .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD), .PCD(PCD),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .ALUControlD(ALUControlD), .ALUSrcD(ALUSrcD),
    .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .ResultSrcD(ResultSrcD),
    .FlushE(FlushE),
    .RdM(RdM), .RegWriteM(RegWriteM), .ALUResultM(ALUResultM),
    .RdW(RdW), .RegWriteW(RegWriteW), .ResultW(ResultW),
    .SrcAE(SrcAE), .SrcBE(SrcBE), .ALUControlE(ALUControlE),
    .WriteDataE(WriteDataE), .PCE(PCE), .ImmExtE(ImmExtE), .RdE(RdE),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE),
    .ValidE(ValidE), .StallF(StallF), .StallD(StallD)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic clear_d();
    ValidD = 0; RD1D = 0; RD2D = 0; ImmExtD = 0; PCD = 0;
    Rs1D = 0; Rs2D = 0; RdD = 0; ALUControlD = 0; ALUSrcD = 0;
    RegWriteD = 0; MemWriteD = 0; ResultSrcD = 0;
  endtask
  initial begin
    reset = 1; FlushE = 0;
    RdM = 0; RegWriteM = 0; ALUResultM = 0; RdW = 0; RegWriteW = 0; ResultW = 0;
    clear_d();
    ValidD = 1; RegWriteD = 1; PCD = 32'h99; ALUControlD = 3'b111;
    step();
    step();
    chk("rst_valid", ValidE, 0);
    chk("rst_regwrite", RegWriteE, 0);
    chk("rst_aluctl", ALUControlE, 0);
    chk("rst_rd", RdE, 0);
    chk("rst_pc", PCE, 0);
    chk("rst_stall", {StallF, StallD}, 0);
    reset = 0;
    clear_d();
    ValidD = 1; Rs1D = 5; Rs2D = 6; RD1D = 0; RD2D = 32'h22; RdD = 8;
    ALUControlD = 3'b001; ImmExtD = 32'h100; PCD = 32'h40; RegWriteD = 1;
    step();
    chk("load_pc", PCE, 32'h40);
    chk("load_rd", RdE, 8);
    chk("load_aluctl", ALUControlE, 3'b001);
    chk("load_valid", ValidE, 1);
    chk("load_imm", ImmExtE, 32'h100);
    chk("nofwd_a", SrcAE, 0);
    RegWriteM = 1; RdM = 5; ALUResultM = 32'h11;
    #1 chk("fwd_m_a", SrcAE, 32'h11);
    chk("nofwd_b", SrcBE, 32'h22);
    RegWriteW = 1; RdW = 5; ResultW = 32'h33;
    #1 chk("fwd_m_prio", SrcAE, 32'h11);
    RegWriteM = 0;
    #1 chk("fwd_w_a", SrcAE, 32'h33);
    RegWriteW = 0;
    #1 chk("fwd_off_a", SrcAE, 0);
    clear_d();
    ValidD = 1; Rs1D = 1; Rs2D = 7; RD2D = 32'h5; RdD = 9; RegWriteD = 1;
    step();
    RdM = 7; RdW = 7; RegWriteM = 1; RegWriteW = 1; ALUResultM = 32'hAA; ResultW = 32'hBB;
    #1 chk("fwd_m_b", SrcBE, 32'hAA);
    chk("fwd_m_wd", WriteDataE, 32'hAA);
    RegWriteM = 0;
    #1 chk("fwd_w_b", SrcBE, 32'hBB);
    RegWriteM = 1;
    clear_d();
    ValidD = 1; Rs1D = 0; Rs2D = 7; RD2D = 32'h5; ALUSrcD = 1; ImmExtD = 32'h123; RegWriteD = 1; RdD = 2;
    step();
    chk("imm_b", SrcBE, 32'h123);
    chk("imm_wd", WriteDataE, 32'hAA);
    RdM = 0; ALUResultM = 32'hFF; RdW = 0; ResultW = 32'hEE;
    #1 chk("x0_a", SrcAE, 0);
    RegWriteM = 0; RegWriteW = 0; RdM = 0; RdW = 0;
    clear_d();
    ValidD = 1; ResultSrcD = 2'b01; RdD = 3; RegWriteD = 1; PCD = 32'h4C;
    step();
    clear_d();
    Rs1D = 9; Rs2D = 3; RdD = 4; RD2D = 32'h77; PCD = 32'h50; RegWriteD = 1;
    #1 chk("nostall_invalid_d", StallF, 0);
    ValidD = 1;
    #1 chk("lu_stallf", StallF, 1);
    chk("lu_stalld", StallD, 1);
    step();
    chk("lu_bubble_valid", ValidE, 0);
    chk("lu_bubble_regwr", RegWriteE, 0);
    chk("lu_bubble_rd", RdE, 0);
    chk("lu_release", StallF, 0);
    step();
    chk("lu_dep_valid", ValidE, 1);
    chk("lu_dep_rd", RdE, 4);
    chk("lu_dep_pc", PCE, 32'h50);
    clear_d();
    ValidD = 1; MemWriteD = 1; PCD = 32'h60; Rs1D = 4; FlushE = 1;
    step();
    chk("flush_memwr", MemWriteE, 0);
    chk("flush_valid", ValidE, 0);
    chk("flush_pc", PCE, 0);
    FlushE = 0;
    clear_d();
    ValidD = 1; PCD = 32'h64; RegWriteD = 1; ResultSrcD = 2'b01; RdD = 3; ALUControlD = 3'b100;
    step();
    chk("post_flush_pc", PCE, 32'h64);
    chk("post_flush_valid", ValidE, 1);
    chk("post_flush_aluctl", ALUControlE, 3'b100);
    clear_d();
    ValidD = 1; Rs1D = 3; RdD = 6; PCD = 32'h68; RegWriteD = 1;
    #1 chk("pre_rst_stall", StallF, 1);
    #2 reset = 1;
    #1 chk("arst_valid", ValidE, 0);
    chk("arst_regwr", RegWriteE, 0);
    chk("arst_aluctl", ALUControlE, 0);
    chk("arst_stall", {StallF, StallD}, 0);
    @(negedge clk);
    reset = 0;
    step();
    chk("resume_valid", ValidE, 1);
    chk("resume_pc", PCE, 32'h68);
    chk("resume_rd", RdE, 6);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
